// File: rtl/n64_demux_ctrl_pkg.sv
// n64_demux_ctrl_pkg: shared constants, encodings and helpers for the N64
// demux control slice (colour width, demux parameter bit positions, deblur
// configuration codes, sync bit positions inside a sync slot).
package n64_demux_ctrl_pkg;

    localparam int COLOR_WIDTH = 7;

    // Lines per frame above which the source is treated as PAL.
    localparam logic [9:0] LINE_THRES = 10'd287;
    localparam logic [9:0] LINE_MAX   = 10'd1023;

    // Odd/even pixel difference limit used by the automatic deblur detector.
    localparam logic [7:0] DEBLUR_THRES = 8'd16;
    localparam logic [7:0] DIFF_MAX     = 8'hFF;

    // Bit positions inside the 5-bit demux parameter word.
    localparam int DP_CNT_HI  = 4;
    localparam int DP_CNT_LO  = 3;
    localparam int DP_VMODE   = 2;
    localparam int DP_NDEBLUR = 1;
    localparam int DP_N16BIT  = 0;

    // Sync bit positions on D_i while nDSYNC is low.
    localparam int SYNC_NVSYNC = 3;
    localparam int SYNC_NCLAMP = 2;
    localparam int SYNC_NHSYNC = 1;
    localparam int SYNC_NCSYNC = 0;

    // Pixel slot codes carried in data_cnt; 00 is the "ignore" slot.
    localparam logic [1:0] SLOT_IDLE = 2'b00;
    localparam logic [1:0] SLOT_R    = 2'b01;
    localparam logic [1:0] SLOT_G    = 2'b10;
    localparam logic [1:0] SLOT_B    = 2'b11;

    typedef enum logic [1:0] {
        DEBLUR_AUTO    = 2'b00,
        DEBLUR_OFF     = 2'b01,
        DEBLUR_ON      = 2'b10,
        DEBLUR_OFF_ALT = 2'b11
    } deblur_cfg_t;

    // Deblur is requested when forced on, or in auto mode with a positive
    // detector verdict; both off encodings fall through to 0.
    function automatic logic deblur_on(input logic [1:0] cfg, input logic auto_result);
        return (cfg == DEBLUR_ON) || ((cfg == DEBLUR_AUTO) && auto_result);
    endfunction

endpackage

// File: rtl/n64_demux_ctrl_if.sv
// n64_demux_ctrl_if: raw N64 video input plus configuration on one side and
// the demux parameter word / video info on the other. The master drives the
// video and config inputs; the slave is the control block.
interface n64_demux_ctrl_if;
    import n64_demux_ctrl_pkg::*;

    logic                   nDSYNC;
    logic [COLOR_WIDTH-1:0] D_i;
    logic [1:0]             deblur_cfg_i;
    logic                   n16bit_mode_i;
    logic [4:0]             demuxparams_o;
    logic                   n64_480i_o;
    logic                   vmode_o;

    modport master (
        output nDSYNC, D_i, deblur_cfg_i, n16bit_mode_i,
        input  demuxparams_o, n64_480i_o, vmode_o
    );

    modport slave (
        input  nDSYNC, D_i, deblur_cfg_i, n16bit_mode_i,
        output demuxparams_o, n64_480i_o, vmode_o
    );

endinterface

// File: rtl/n64_demux_ctrl_deblur_det.sv
// n64_deblur_det: automatic deblur detector, present only when
// N64_DEBLUR_AUTO_EN is defined. Rebuilds each RGB pixel from the three data
// slots, compares it with the previous pixel and counts differences separately
// for odd and even pixel positions within a line. A frame whose odd pixels
// repeat their even neighbours is a horizontally doubled (blurred) source.
`ifdef N64_DEBLUR_AUTO_EN
module n64_deblur_det
    import n64_demux_ctrl_pkg::*;
(
    input  logic                   VCLK,
    input  logic                   nRST,
    input  logic                   nDSYNC,
    input  logic [COLOR_WIDTH-1:0] D_i,
    input  logic [1:0]             data_cnt,
    input  logic                   negedge_nhsync,
    input  logic                   negedge_nvsync,
    output logic                   auto_result
);

    logic [COLOR_WIDTH-1:0]   r_q;
    logic [COLOR_WIDTH-1:0]   g_q;
    logic [3*COLOR_WIDTH-1:0] prev_pix;
    logic [3*COLOR_WIDTH-1:0] cur_pix;
    logic                     parity;
    logic [7:0]               diff_odd;
    logic [7:0]               diff_even;
    logic                     pix_done;
    logic                     pix_diff;

    // The blue slot completes a pixel; compare it with the previous one.
    always_comb begin
        cur_pix  = {r_q, g_q, D_i};
        pix_done = nDSYNC && (data_cnt == SLOT_B);
        pix_diff = pix_done && (cur_pix != prev_pix);
    end

    // Pixel assembly, parity tracking, difference counting and frame verdict.
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            // NOTE: the pixel history is reset as well so the first comparison
            // after reset is against a known value rather than X.
            r_q         <= '0;
            g_q         <= '0;
            prev_pix    <= '0;
            parity      <= 1'b0;
            diff_odd    <= '0;
            diff_even   <= '0;
            auto_result <= 1'b0;
        end else begin
            if (nDSYNC) begin
                if (data_cnt == SLOT_R) r_q <= D_i;
                if (data_cnt == SLOT_G) g_q <= D_i;
                if (pix_done) prev_pix <= cur_pix;
            end else begin
                parity <= negedge_nhsync ? 1'b0 : ~parity;
            end

            if (negedge_nvsync) begin
                auto_result <= (diff_odd < DEBLUR_THRES) && (diff_even >= DEBLUR_THRES);
                diff_odd    <= '0;
                diff_even   <= '0;
            end else if (pix_diff) begin
                if (parity) begin
                    if (diff_odd != DIFF_MAX) diff_odd <= diff_odd + 8'd1;
                end else begin
                    if (diff_even != DIFF_MAX) diff_even <= diff_even + 8'd1;
                end
            end
        end
    end

endmodule
`endif

// File: rtl/n64_demux_ctrl.sv
// n64_demux_ctrl: produces the 5-bit demux parameter word
// {data_cnt, vmode, ndo_deblur, n16bit_mode} from the raw VCLK/nDSYNC/D_i
// stream. Tracks the 4-phase pixel slot, counts lines per frame for PAL/NTSC,
// detects 480i and latches deblur / 16-bit mode only at the falling edge of
// nVSYNC so the demux never sees a mid-frame change.
// Optional feature: define N64_DEBLUR_AUTO_EN to add the automatic deblur
// detector; otherwise the auto setting behaves as deblur off.
module n64_demux_ctrl
    import n64_demux_ctrl_pkg::*;
(
    input  logic              VCLK,
    input  logic              nRST,
    n64_demux_ctrl_if.slave   bus
);

    logic [1:0] data_cnt;
    logic       vmode;
    logic       ndo_deblur;
    logic       n16bit_mode;
    logic       n64_480i;
    logic [9:0] line_cnt;
    logic [3:0] sync_prev;
    logic       field_phase;

    logic       sync_slot;
    logic       negedge_nvsync;
    logic       negedge_nhsync;
    logic       auto_result;

    // Sync edges are only meaningful inside sync slots.
    always_comb begin
        // NOTE: defaults first so every path assigns each output; no latches.
        sync_slot      = 1'b0;
        negedge_nvsync = 1'b0;
        negedge_nhsync = 1'b0;
        if (!bus.nDSYNC) begin
            sync_slot      = 1'b1;
            negedge_nvsync = sync_prev[SYNC_NVSYNC] & ~bus.D_i[SYNC_NVSYNC];
            negedge_nhsync = sync_prev[SYNC_NHSYNC] & ~bus.D_i[SYNC_NHSYNC];
        end
    end

`ifdef N64_DEBLUR_AUTO_EN
    n64_deblur_det u_deblur_det (
        .VCLK           (VCLK),
        .nRST           (nRST),
        .nDSYNC         (bus.nDSYNC),
        .D_i            (bus.D_i),
        .data_cnt       (data_cnt),
        .negedge_nhsync (negedge_nhsync),
        .negedge_nvsync (negedge_nvsync),
        .auto_result    (auto_result)
    );
`else
    assign auto_result = 1'b0;
`endif

    // Slot counter, sync history, line counter and frame-boundary latches.
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            data_cnt    <= SLOT_IDLE;
            vmode       <= 1'b0;
            ndo_deblur  <= 1'b1;
            n16bit_mode <= 1'b1;
            n64_480i    <= 1'b0;
            line_cnt    <= '0;
            sync_prev   <= 4'hF;
            field_phase <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so n64_480i below is read as its
            // previous-frame value when ndo_deblur is computed on the same edge.
            data_cnt <= bus.nDSYNC ? data_cnt + 2'd1 : SLOT_R;

            if (sync_slot) sync_prev <= bus.D_i[3:0];

            // vsync wins over a coincident hsync: compare the pre-increment count.
            if (negedge_nvsync) begin
                vmode       <= (line_cnt > LINE_THRES);
                line_cnt    <= '0;
                field_phase <= bus.D_i[SYNC_NHSYNC];
                n64_480i    <= (bus.D_i[SYNC_NHSYNC] != field_phase);
                n16bit_mode <= bus.n16bit_mode_i;
                ndo_deblur  <= n64_480i | ~deblur_on(bus.deblur_cfg_i, auto_result);
            end else if (negedge_nhsync && (line_cnt != LINE_MAX)) begin
                line_cnt <= line_cnt + 10'd1;
            end
        end
    end

    assign bus.demuxparams_o[DP_CNT_HI:DP_CNT_LO] = data_cnt;
    assign bus.demuxparams_o[DP_VMODE]            = vmode;
    assign bus.demuxparams_o[DP_NDEBLUR]          = ndo_deblur;
    assign bus.demuxparams_o[DP_N16BIT]           = n16bit_mode;
    assign bus.n64_480i_o                         = n64_480i;
    assign bus.vmode_o                            = vmode;

    // Clamp/csync levels and the colour bits are carried but not decoded here.
    logic unused_bits;
    assign unused_bits = ^{sync_prev[SYNC_NCLAMP], sync_prev[SYNC_NCSYNC], bus.D_i};

endmodule

// File: tb/tb_n64_demux_ctrl.sv
// tb_n64_demux_ctrl: drives N64-style slot streams into n64_demux_ctrl.
// A reference model predicts the registered outputs for every driven cycle;
// predictions are queued at drive time and compared one edge later. Each test
// task adds directed checks against fixed expected values.
module tb_n64_demux_ctrl;
    import n64_demux_ctrl_pkg::*;

    logic VCLK = 1'b0;
    logic nRST = 1'b0;

    n64_demux_ctrl_if bus ();

    n64_demux_ctrl dut (
        .VCLK (VCLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 VCLK = ~VCLK;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [1:0] cfg    = 2'b01;
    logic       n16_in = 1'b1;

    // Reference model state.
    logic [1:0]  m_dc;
    logic [3:0]  m_sp;
    logic [9:0]  m_line;
    logic        m_vmode, m_ndb, m_n16, m_480i, m_phase;
    logic        m_auto, m_par;
    logic [6:0]  m_r, m_g;
    logic [20:0] m_prev;
    logic [7:0]  m_dodd, m_deven;

    typedef struct packed {
        logic [4:0] dp;
        logic       i480;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic model_reset();
        m_dc = 2'b00; m_sp = 4'hF; m_line = '0; m_vmode = 1'b0; m_ndb = 1'b1;
        m_n16 = 1'b1; m_480i = 1'b0; m_phase = 1'b0; m_auto = 1'b0; m_par = 1'b0;
        m_r = '0; m_g = '0; m_prev = '0; m_dodd = '0; m_deven = '0;
    endtask

    // Advance the model by one VCLK edge with the given inputs.
    task automatic model_step(input logic nd, input logic [6:0] d);
        logic sync, nv, nh, on;
        logic [20:0] pix;
        sync = !nd;
        nv   = sync && m_sp[3] && !d[3];
        nh   = sync && m_sp[1] && !d[1];
        on   = (cfg == 2'b10) || ((cfg == 2'b00) && m_auto);
        if (nv) begin
            m_vmode = (m_line > 10'd287);
            m_line  = '0;
            m_ndb   = m_480i || !on;
            m_n16   = n16_in;
            m_480i  = (d[1] != m_phase);
            m_phase = d[1];
        end else if (nh && (m_line != 10'd1023)) begin
            m_line = m_line + 10'd1;
        end
`ifdef N64_DEBLUR_AUTO_EN
        if (nd) begin
            if (m_dc == 2'd1) m_r = d;
            if (m_dc == 2'd2) m_g = d;
            if (m_dc == 2'd3) begin
                pix = {m_r, m_g, d};
                if (pix != m_prev) begin
                    if (m_par) begin
                        if (m_dodd != 8'hFF) m_dodd = m_dodd + 8'd1;
                    end else begin
                        if (m_deven != 8'hFF) m_deven = m_deven + 8'd1;
                    end
                end
                m_prev = pix;
            end
        end else begin
            if (nv) begin
                m_auto  = (m_dodd < 8'd16) && (m_deven >= 8'd16);
                m_dodd  = '0;
                m_deven = '0;
            end
            m_par = nh ? 1'b0 : !m_par;
        end
`else
        pix = '0;
`endif
        m_dc = nd ? m_dc + 2'd1 : 2'd1;
        if (sync) m_sp = d[3:0];
    endtask

    // Drive one cycle at the falling edge and queue the predicted outputs.
    task automatic cyc(input logic nd, input logic [6:0] d);
        bus.nDSYNC        = nd;
        bus.D_i           = d;
        bus.deblur_cfg_i  = cfg;
        bus.n16bit_mode_i = n16_in;
        model_step(nd, d);
        exp_q.push_back('{dp: {m_dc, m_vmode, m_ndb, m_n16}, i480: m_480i});
        @(negedge VCLK);
    endtask

    // Scoreboard: compare each queued prediction just after the edge it covers.
    always @(posedge VCLK) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            total_cnt++;
            if (bus.demuxparams_o !== mon_e.dp || bus.n64_480i_o !== mon_e.i480 ||
                bus.vmode_o !== mon_e.dp[2])
                $display("FAIL scoreboard t=%0t: dp=%b 480i=%b vmode=%b, required dp=%b 480i=%b",
                         $time, bus.demuxparams_o, bus.n64_480i_o, bus.vmode_o, mon_e.dp, mon_e.i480);
            else
                pass_cnt++;
        end
    end

    // One sync slot followed by R, G, B data slots.
    task automatic pixel(input logic vs, input logic hs, input logic [6:0] v);
        cyc(1'b0, {3'b000, vs, 1'b1, hs, 1'b1});
        cyc(1'b1, v);
        cyc(1'b1, v);
        cyc(1'b1, v);
    endtask

    // Each line: hsync falls on its first pixel, rises on its second.
    task automatic lines(input int n);
        for (int i = 0; i < n; i++) begin
            pixel(1'b1, 1'b0, 7'(i));
            pixel(1'b1, 1'b1, 7'(i));
        end
    endtask

    task automatic vsync(input logic phase);
        pixel(1'b0, phase, 7'h55);
        pixel(1'b1, 1'b1, 7'h55);
    endtask

    task automatic test_reset();
        bus.nDSYNC = 1'b1; bus.D_i = 7'h0F; bus.deblur_cfg_i = cfg; bus.n16bit_mode_i = n16_in;
        nRST = 1'b0;
        repeat (3) @(negedge VCLK);
        total_cnt++;
        if (bus.demuxparams_o !== 5'b00011 || bus.n64_480i_o !== 1'b0)
            $display("FAIL reset_state: dp=%b 480i=%b, required 00011 0", bus.demuxparams_o, bus.n64_480i_o);
        else pass_cnt++;
        model_reset();
        nRST = 1'b1;
    endtask

    task automatic test_slots();
        logic       nd_tab  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0] exp_tab [7] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b01, 2'b10};
        for (int i = 0; i < 7; i++) begin
            cyc(nd_tab[i], nd_tab[i] ? 7'h00 : 7'h0F);
            total_cnt++;
            if (bus.demuxparams_o[4:3] !== exp_tab[i])
                $display("FAIL slot_seq[%0d]: data_cnt=%b, required %b", i, bus.demuxparams_o[4:3], exp_tab[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_pal_ntsc();
        int         n_tab [5] = '{5, 312, 287, 288, 262};
        logic       v_tab [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            lines(n_tab[i]);
            vsync(1'b0);
            total_cnt++;
            if (bus.vmode_o !== v_tab[i] || bus.demuxparams_o[2] !== v_tab[i])
                $display("FAIL vmode_%0d_lines: vmode=%b dp[2]=%b, required %b",
                         n_tab[i], bus.vmode_o, bus.demuxparams_o[2], v_tab[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_interlace();
        logic ph_tab  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic i_tab   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic ndb_tab [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            if (i == 2) cfg = 2'b10;
            lines(10);
            vsync(ph_tab[i]);
            total_cnt++;
            if (bus.n64_480i_o !== i_tab[i] || bus.demuxparams_o[1] !== ndb_tab[i])
                $display("FAIL interlace[%0d]: 480i=%b ndo_deblur=%b, required %b %b",
                         i, bus.n64_480i_o, bus.demuxparams_o[1], i_tab[i], ndb_tab[i]);
            else pass_cnt++;
        end
        cfg = 2'b01;
    endtask

    task automatic test_config_latch();
        lines(5);
        n16_in = 1'b0;
        lines(5);
        total_cnt++;
        if (bus.demuxparams_o[0] !== 1'b1)
            $display("FAIL n16bit_mid_frame: dp[0]=%b, required 1", bus.demuxparams_o[0]);
        else pass_cnt++;
        vsync(1'b0);
        total_cnt++;
        if (bus.demuxparams_o[0] !== 1'b0)
            $display("FAIL n16bit_at_vsync: dp[0]=%b, required 0", bus.demuxparams_o[0]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        lines(3);
        vsync(1'b1);
        lines(2);
        total_cnt++;
        if (bus.n64_480i_o !== 1'b1 || bus.demuxparams_o[0] !== 1'b0)
            $display("FAIL pre_reset_state: 480i=%b dp[0]=%b, required 1 0", bus.n64_480i_o, bus.demuxparams_o[0]);
        else pass_cnt++;
        #2 nRST = 1'b0;
        #1;
        total_cnt++;
        if (bus.demuxparams_o !== 5'b00011 || bus.n64_480i_o !== 1'b0)
            $display("FAIL async_reset: dp=%b 480i=%b, required 00011 0", bus.demuxparams_o, bus.n64_480i_o);
        else pass_cnt++;
        model_reset();
        n16_in = 1'b1;
        repeat (2) @(negedge VCLK);
        nRST = 1'b1;
    endtask

    task automatic test_auto_deblur();
        logic exp_ndb;
`ifdef N64_DEBLUR_AUTO_EN
        exp_ndb = 1'b0;
`else
        exp_ndb = 1'b1;
`endif
        cfg = 2'b00;
        lines(200);
        vsync(1'b0);
        total_cnt++;
        if (bus.demuxparams_o[1] !== 1'b1)
            $display("FAIL auto_first_vsync: ndo_deblur=%b, required 1", bus.demuxparams_o[1]);
        else pass_cnt++;
        lines(20);
        vsync(1'b0);
        total_cnt++;
        if (bus.demuxparams_o[1] !== exp_ndb || bus.n64_480i_o !== 1'b0)
            $display("FAIL auto_deblur: ndo_deblur=%b 480i=%b, required %b 0",
                     bus.demuxparams_o[1], bus.n64_480i_o, exp_ndb);
        else pass_cnt++;
    endtask

    initial begin
        model_reset();
        @(negedge VCLK);
        test_reset();
        test_slots();
        test_pal_ntsc();
        test_interlace();
        test_config_latch();
        test_reset_mid();
        test_auto_deblur();
        repeat (2) @(negedge VCLK);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: run did not complete, required completion within 5 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
